// File: rtl/wisc_pkg.sv
// Shared definitions for the instruction-side memory path: word width,
// the NOP returned on bad fetches, responder state type and address check.
package wisc_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } imem_state_t;

  // Byte address must be halfword aligned and fall inside the stored words.
  function automatic logic addr_ok(input logic [15:0] addr, input int unsigned depth);
    return (addr[0] == 1'b0) && (32'(addr) < 2 * depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 16 instruction storage: one load write port and one read port whose
// value is captured by the responder; a same-edge write is forwarded to the read.
module imem_array
  import wisc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A load landing on the capture edge must be seen by the fetch being captured.
  assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/imem_resp.sv
// Multi-cycle instruction memory responder: one outstanding fetch, fixed
// latency, response held until consumed, flushable, with a program-load port.
module imem_resp
  import wisc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LAT   = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic [15:0]       req_addr_i,
  output logic              req_ready_o,
  input  logic              flush_i,
  output logic              rsp_valid_o,
  output logic [WORD_W-1:0] rsp_instr_o,
  output logic              rsp_err_o,
  input  logic              rsp_ready_i,
  input  logic              ld_en_i,
  input  logic [15:0]       ld_addr_i,
  input  logic [WORD_W-1:0] ld_data_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  imem_state_t       state_q;
  logic [3:0]        cnt_q;
  logic [AW-1:0]     addr_q;
  logic              err_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_instr_q;
  logic              rsp_err_q;

  logic              accept;
  logic              ld_we;
  logic [AW-1:0]     rd_idx_d;
  logic [WORD_W-1:0] rd_data;
  logic              cap_err_d;
  logic [WORD_W-1:0] cap_instr_d;

  assign req_ready_o = (state_q == IDLE) && !flush_i && !ld_en_i;
  assign accept      = req_valid_i && req_ready_o;
  assign ld_we       = ld_en_i && addr_ok(ld_addr_i, DEPTH);

  // In IDLE the capture (LAT=1) uses the live request; otherwise the latched one.
  assign rd_idx_d    = (state_q == IDLE) ? req_addr_i[AW:1] : addr_q;
  assign cap_err_d   = (state_q == IDLE) ? !addr_ok(req_addr_i, DEPTH) : err_q;
  assign cap_instr_d = cap_err_d ? NOP_INSTR : rd_data;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (ld_we),
    .waddr_i (ld_addr_i[AW:1]),
    .wdata_i (ld_data_i),
    .raddr_i (rd_idx_d),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr_i[AW:1];
            err_q  <= !addr_ok(req_addr_i, DEPTH);
            if (LAT == 1) begin
              state_q     <= DONE;
              rsp_valid_q <= 1'b1;
              rsp_instr_q <= cap_instr_d;
              rsp_err_q   <= cap_err_d;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          // Capture on the edge where the countdown reaches zero.
          if (cnt_q == 4'd1) begin
            cnt_q       <= '0;
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_instr_q <= cap_instr_d;
            rsp_err_q   <= cap_err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_instr_o = rsp_instr_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_imem_resp.sv
// Randomized scoreboard bench for imem_resp: a word-array reference model
// predicts each fetch result and response timing; a monitor checks responses.
module tb_imem_resp;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  typedef struct {
    logic [15:0] instr;
    logic        err;
    logic [15:0] addr;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        rsp_valid;
  logic [15:0] rsp_instr;
  logic        rsp_err;
  logic        rsp_ready;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  int   nCompared = 0;
  int   nMismatch = 0;
  int   cyc = 0;
  bit   started = 1'b0;

  exp_t        expQ[$];
  logic [15:0] memM [DEPTH];
  bit          busyM = 1'b0;
  int          accCyc = 0;

  imem_resp #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .flush_i     (flush),
    .rsp_valid_o (rsp_valid),
    .rsp_instr_o (rsp_instr),
    .rsp_err_o   (rsp_err),
    .rsp_ready_i (rsp_ready),
    .ld_en_i     (ld_en),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic bit addrGood(input logic [15:0] a);
    return (a[0] == 1'b0) && (a < 16'(2 * DEPTH));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus plus the reference model's view of that cycle.
  task automatic applyStimulus(input logic rv, input logic [15:0] ra, input logic fl,
                               input logic rr, input logic ld, input logic [15:0] la,
                               input logic [15:0] ldd);
    logic expValid;
    logic expReady;
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = rv;
    req_addr  = ra;
    flush     = fl;
    rsp_ready = rr;
    ld_en     = ld;
    ld_addr   = la;
    ld_data   = ldd;
    @(negedge clk);
    expValid = busyM && ((cyc - accCyc) >= LAT);
    expReady = !busyM && !fl && !ld;
    checkOutput("req_ready", {31'd0, req_ready}, {31'd0, expReady});
    checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, expValid});
    if (ld && addrGood(la)) begin
      memM[la[8:1]] = ldd;
      // A load is seen by the in-flight fetch if it lands by the capture edge.
      if (busyM && expQ.size() > 0 && !expQ[$].err && expQ[$].addr == la
          && cyc <= accCyc + LAT - 1) begin
        expQ[$].instr = ldd;
      end
    end
    if (fl) begin
      if (busyM) begin
        if (expQ.size() > 0) void'(expQ.pop_back());
        busyM = 1'b0;
      end
    end else if (expValid && rr) begin
      busyM = 1'b0;
    end else if (rv && expReady) begin
      e.addr  = ra;
      e.err   = !addrGood(ra);
      e.instr = e.err ? 16'h0800 : memM[ra[8:1]];
      e.acc   = cyc;
      expQ.push_back(e);
      busyM   = 1'b1;
      accCyc  = cyc;
    end
  endtask

  task automatic idleCycles(input int n, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 1'b0, rr, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic fetch(input logic [15:0] a);
    applyStimulus(1'b1, a, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    idleCycles(LAT + 1, 1'b1);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin : monitor
    bit prevValid;
    int validSince;
    prevValid  = 1'b0;
    validSince = 0;
    wait (started);
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid && !prevValid) validSince = cyc;
      prevValid = rsp_valid;
      if (rsp_valid && !flush) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          checkOutput("rsp_instr", {16'd0, rsp_instr}, {16'd0, expQ[0].instr});
          checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, expQ[0].err});
          if (rsp_ready) begin
            checkOutput("latency", validSince - expQ[0].acc, LAT);
            void'(expQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] la;
    int r;
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    #12;
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_instr", {16'd0, rsp_instr}, 32'd0);
    checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    rst_ni  = 1'b1;
    started = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'(i * 2), 16'($urandom));
    end

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h1234);
    fetch(16'h0004);
    fetch(16'h0003);
    fetch(16'h0200);

    // Hold the response for several cycles while new requests knock.
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < LAT + 5; i++) applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idleCycles(2, 1'b1);

    // Flush one cycle after acceptance, then a fresh request.
    applyStimulus(1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
    fetch(16'h0006);

    // Flush together with consumption drops the response.
    applyStimulus(1'b1, 16'h0032, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idleCycles(LAT, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
    idleCycles(2, 1'b1);

    // Load and request in the same idle cycle; the load wins.
    applyStimulus(1'b1, 16'h0008, 1'b0, 1'b1, 1'b1, 16'h0008, 16'hBEEF);
    fetch(16'h0008);

    // Load on the capture edge is visible; load after capture is not.
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'hAAAA);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h5555);
    idleCycles(2, 1'b1);
    fetch(16'h0010);

    // Reset while busy discards the fetch but keeps memory.
    applyStimulus(1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    #1;
    checkOutput("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    expQ.delete();
    busyM = 1'b0;
    @(negedge clk);
    #3;
    rst_ni = 1'b1;
    fetch(16'h0004);
    fetch(16'h0008);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      ra = 16'($urandom) | 16'h0001;
      else if (r == 1) ra = 16'($urandom_range(2 * DEPTH, 65535));
      else             ra = 16'($urandom_range(0, DEPTH - 1)) << 1;
      la = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (16'($urandom_range(0, DEPTH - 1)) << 1);
      applyStimulus(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), la,
                    16'($urandom));
    end

    idleCycles(LAT + 3, 1'b1);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
